// File: rtl/dmem_arbiter.sv
// Two-port arbiter that shares a single-port data memory between the CPU port (0) and a
// secondary master (1), with range/alignment rejection, lock support and registered responses.
`timescale 1ns / 1ps

module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT     = 512,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        p0_valid,
  input  logic        p0_write,
  input  logic        p0_lock,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ready,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,

  input  logic        p1_valid,
  input  logic        p1_write,
  input  logic        p1_lock,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ready,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,

  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    LockNone = 2'b00,
    LockP0   = 2'b01,
    LockP1   = 2'b10
  } lock_e;

  lock_e       r_lock_state;
  lock_e       w_lock_next;
  logic        r_last_grant;   // port granted by the most recent accepted request

  logic        r_p0_rvalid;
  logic        r_p0_err;
  logic [31:0] r_p0_rdata;
  logic        r_p1_rvalid;
  logic        r_p1_err;
  logic [31:0] r_p1_rdata;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_any_grant;
  logic        w_err0;
  logic        w_err1;
  logic        w_sel_err;
  logic        w_sel_write;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;

  assign w_err0 = (p0_addr >= 32'(ADDR_LIMIT)) || (p0_addr[1:0] != 2'b00);
  assign w_err1 = (p1_addr >= 32'(ADDR_LIMIT)) || (p1_addr[1:0] != 2'b00);

  // A lock owner blocks the other port even while the owner itself is idle.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (reset) begin
      unique case (r_lock_state)
        LockP0: w_grant0 = p0_valid;
        LockP1: w_grant1 = p1_valid;
        default: begin
          if (p0_valid && p1_valid) begin
            if ((FIXED_PRIORITY != 0) || r_last_grant) begin
              w_grant0 = 1'b1;
            end else begin
              w_grant1 = 1'b1;
            end
          end else begin
            w_grant0 = p0_valid;
            w_grant1 = p1_valid;
          end
        end
      endcase
    end
  end

  assign w_any_grant = w_grant0 | w_grant1;
  assign w_sel_err   = w_grant1 ? w_err1   : w_err0;
  assign w_sel_write = w_grant1 ? p1_write : p0_write;
  assign w_sel_addr  = w_grant1 ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_grant1 ? p1_wdata : p0_wdata;

  always_comb begin
    mem_address = '0;
    mem_wdata   = '0;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    if (w_any_grant && !w_sel_err) begin
      mem_address = w_sel_addr;
      if (w_sel_write) begin
        mem_write = 1'b1;
        mem_wdata = w_sel_wdata;
      end else begin
        mem_read = 1'b1;
      end
    end
  end

  // Only a granted port can touch the lock, and a locked state only ever grants its owner.
  always_comb begin
    w_lock_next = r_lock_state;
    if (w_grant0) begin
      w_lock_next = p0_lock ? LockP0 : LockNone;
    end else if (w_grant1) begin
      w_lock_next = p1_lock ? LockP1 : LockNone;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lock_state <= LockNone;
      r_last_grant <= 1'b1;
      r_p0_rvalid  <= 1'b0;
      r_p0_err     <= 1'b0;
      r_p0_rdata   <= '0;
      r_p1_rvalid  <= 1'b0;
      r_p1_err     <= 1'b0;
      r_p1_rdata   <= '0;
    end else begin
      r_lock_state <= w_lock_next;
      if (w_any_grant) begin
        r_last_grant <= w_grant1;
      end
      r_p0_rvalid <= w_grant0;
      r_p0_err    <= w_grant0 & w_err0;
      r_p0_rdata  <= (w_grant0 && !w_err0 && !p0_write) ? mem_rdata : '0;
      r_p1_rvalid <= w_grant1;
      r_p1_err    <= w_grant1 & w_err1;
      r_p1_rdata  <= (w_grant1 && !w_err1 && !p1_write) ? mem_rdata : '0;
    end
  end

  assign p0_ready  = w_grant0;
  assign p1_ready  = w_grant1;
  assign p0_rvalid = r_p0_rvalid;
  assign p0_err    = r_p0_err;
  assign p0_rdata  = r_p0_rdata;
  assign p1_rvalid = r_p1_rvalid;
  assign p1_err    = r_p1_err;
  assign p1_rdata  = r_p1_rdata;

endmodule
